// File: rtl/ppu_scroll_pkg.sv
// Shared definitions for the PPU loopy scroll registers.
// Holds v/t bit-field offsets, PPU register indices and the pure coarse X / Y increment functions.
// Loopy address layout: yyy NN YYYYY XXXXX  (fineY, nametable Y/X, coarseY, coarseX).
package ppu_scroll_pkg;

  localparam int LOOPY_W      = 15;

  // Bit-field offsets inside v / t
  localparam int COARSE_X_LSB = 0;
  localparam int COARSE_Y_LSB = 5;
  localparam int NT_X_BIT     = 10;
  localparam int NT_Y_BIT     = 11;
  localparam int FINE_Y_LSB   = 12;

  // PPU register indices ($2000 + n)
  localparam logic [2:0] PPUCTRL   = 3'd0;
  localparam logic [2:0] PPUSTATUS = 3'd2;
  localparam logic [2:0] PPUSCROLL = 3'd5;
  localparam logic [2:0] PPUADDR   = 3'd6;
  localparam logic [2:0] PPUDATA   = 3'd7;

  // Coarse X increment; wrapping past tile 31 flips to the horizontally adjacent nametable.
  function automatic logic [LOOPY_W-1:0] loopy_inc_x(input logic [LOOPY_W-1:0] v);
    logic [LOOPY_W-1:0] r;
    r = v;
    if (v[COARSE_X_LSB +: 5] == 5'd31) begin
      r[COARSE_X_LSB +: 5] = 5'd0;
      r[NT_X_BIT]          = ~v[NT_X_BIT];
    end else begin
      r[COARSE_X_LSB +: 5] = v[COARSE_X_LSB +: 5] + 5'd1;
    end
    return r;
  endfunction

  // Fine/coarse Y increment. Row 29 is the last visible tile row and flips the vertical
  // nametable; rows 30/31 hold attribute data, and 31 wraps to 0 without flipping.
  function automatic logic [LOOPY_W-1:0] loopy_inc_y(input logic [LOOPY_W-1:0] v);
    logic [LOOPY_W-1:0] r;
    r = v;
    if (v[FINE_Y_LSB +: 3] != 3'd7) begin
      r[FINE_Y_LSB +: 3] = v[FINE_Y_LSB +: 3] + 3'd1;
    end else begin
      r[FINE_Y_LSB +: 3] = 3'd0;
      if (v[COARSE_Y_LSB +: 5] == 5'd29) begin
        r[COARSE_Y_LSB +: 5] = 5'd0;
        r[NT_Y_BIT]          = ~v[NT_Y_BIT];
      end else if (v[COARSE_Y_LSB +: 5] == 5'd31) begin
        r[COARSE_Y_LSB +: 5] = 5'd0;
      end else begin
        r[COARSE_Y_LSB +: 5] = v[COARSE_Y_LSB +: 5] + 5'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ppu_loopy_incrementer.sv
// Combinational next-v generator: coarse X step, Y step, and the dot-256 composite (X then Y).
// Latency: zero (pure combinational). Backpressure: none.
// Ports: v_in (current v) -> v_inc_x, v_inc_y, v_inc_xy (candidate next values).
module ppu_loopy_incrementer
  import ppu_scroll_pkg::*;
(
  input  logic [LOOPY_W-1:0] v_in,
  output logic [LOOPY_W-1:0] v_inc_x,
  output logic [LOOPY_W-1:0] v_inc_y,
  output logic [LOOPY_W-1:0] v_inc_xy
);

  always_comb begin
    v_inc_x  = loopy_inc_x(v_in);
    v_inc_y  = loopy_inc_y(v_in);
    // X and Y touch disjoint fields, but composing keeps the ordering explicit.
    v_inc_xy = loopy_inc_y(loopy_inc_x(v_in));
  end

endmodule

// File: rtl/ppu_scroll_registers.sv
// PPU loopy scroll state (v, t, fine X, write toggle w, inc32) fed by CPU register accesses and render strobes.
// Latency: one clock; every output is a flop updated on the edge that samples the access/strobe.
// Backpressure: none; CPU strobes are always accepted, render strobes act only when clock_EN=1.
// Ports: clock/reset (sync, active-high); clock_EN, background_EN, sprite_EN, lineCount,
//   incrementX/Y, resetX/Y from the render controller; reg_wr/reg_rd/reg_addr/reg_wdata CPU side;
//   outputs vramAddr (v), tempAddr (t), fineX, writeToggle (w), inc32.
// Build option: PPUDATA_RENDER_GLITCH_EN makes PPUDATA accesses during rendering do the dot-256 X+Y step.
module ppu_scroll_registers
  import ppu_scroll_pkg::*;
#(
  parameter int ADDR_W          = 15,
  parameter int PRE_RENDER_LINE = 261,
  parameter int VISIBLE_LINES   = 240
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clock_EN,
  input  logic              background_EN,
  input  logic              sprite_EN,
  input  logic [8:0]        lineCount,
  input  logic              incrementX,
  input  logic              incrementY,
  input  logic              resetX,
  input  logic              resetY,
  input  logic              reg_wr,
  input  logic              reg_rd,
  input  logic [2:0]        reg_addr,
  input  logic [7:0]        reg_wdata,
  output logic [ADDR_W-1:0] vramAddr,
  output logic [ADDR_W-1:0] tempAddr,
  output logic [2:0]        fineX,
  output logic              writeToggle,
  output logic              inc32
);

  logic [ADDR_W-1:0] v_q, v_d;
  logic [ADDR_W-1:0] t_q, t_d;
  logic [2:0]        fine_x_q, fine_x_d;
  logic              w_q, w_d;
  logic              inc32_q, inc32_d;

  logic [ADDR_W-1:0] v_inc_x, v_inc_y, v_inc_xy;
  logic [ADDR_W-1:0] render_v;
  logic [ADDR_W-1:0] linear_v;
  logic [ADDR_W-1:0] data_v;
  logic              render_active;
  logic              cpu_wr, cpu_rd;

  ppu_loopy_incrementer u_inc (
    .v_in     (v_q),
    .v_inc_x  (v_inc_x),
    .v_inc_y  (v_inc_y),
    .v_inc_xy (v_inc_xy)
  );

  assign render_active = (background_EN | sprite_EN) &&
                         ((lineCount < 9'(VISIBLE_LINES)) || (lineCount == 9'(PRE_RENDER_LINE)));

  // Simultaneous read+write is a protocol error; the write is honoured and the read dropped.
  assign cpu_wr = reg_wr;
  assign cpu_rd = reg_rd & ~reg_wr;

  assign linear_v = v_q + (inc32_q ? ADDR_W'(32) : ADDR_W'(1));

`ifdef PPUDATA_RENDER_GLITCH_EN
  assign data_v = render_active ? v_inc_xy : linear_v;
`else
  // Render state has no consumer in this build.
  logic render_active_unused;
  assign render_active_unused = render_active;
  assign data_v = linear_v;
`endif

  // Render-path candidate: increments first, then t->v copies override their own fields.
  always_comb begin
    render_v = v_q;
    if (incrementX && incrementY) begin
      render_v = v_inc_xy;
    end else if (incrementX) begin
      render_v = v_inc_x;
    end else if (incrementY) begin
      render_v = v_inc_y;
    end
    if (resetX) begin
      render_v[COARSE_X_LSB +: 5] = t_q[COARSE_X_LSB +: 5];
      render_v[NT_X_BIT]          = t_q[NT_X_BIT];
    end
    if (resetY) begin
      render_v[FINE_Y_LSB +: 3]   = t_q[FINE_Y_LSB +: 3];
      render_v[NT_Y_BIT]          = t_q[NT_Y_BIT];
      render_v[COARSE_Y_LSB +: 5] = t_q[COARSE_Y_LSB +: 5];
    end
  end

  always_comb begin
    t_d      = t_q;
    fine_x_d = fine_x_q;
    w_d      = w_q;
    inc32_d  = inc32_q;
    v_d      = v_q;

    if (cpu_wr) begin
      case (reg_addr)
        PPUCTRL: begin
          t_d[NT_Y_BIT:NT_X_BIT] = reg_wdata[1:0];
          inc32_d                = reg_wdata[2];
        end
        PPUSCROLL: begin
          if (!w_q) begin
            t_d[COARSE_X_LSB +: 5] = reg_wdata[7:3];
            fine_x_d               = reg_wdata[2:0];
            w_d                    = 1'b1;
          end else begin
            t_d[COARSE_Y_LSB +: 5] = reg_wdata[7:3];
            t_d[FINE_Y_LSB +: 3]   = reg_wdata[2:0];
            w_d                    = 1'b0;
          end
        end
        PPUADDR: begin
          if (!w_q) begin
            t_d[13:8] = reg_wdata[5:0];
            t_d[14]   = 1'b0;
            w_d       = 1'b1;
          end else begin
            t_d[7:0]  = reg_wdata;
            w_d       = 1'b0;
          end
        end
        default: ;
      endcase
    end else if (cpu_rd && (reg_addr == PPUSTATUS)) begin
      w_d = 1'b0;
    end

    // v priority: PPUADDR second-write copy, then PPUDATA access, then render operations.
    if (cpu_wr && (reg_addr == PPUADDR) && w_q) begin
      v_d = t_d;
    end else if ((cpu_wr || cpu_rd) && (reg_addr == PPUDATA)) begin
      v_d = data_v;
    end else if (clock_EN) begin
      v_d = render_v;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      v_q      <= '0;
      t_q      <= '0;
      fine_x_q <= '0;
      w_q      <= 1'b0;
      inc32_q  <= 1'b0;
    end else begin
      v_q      <= v_d;
      t_q      <= t_d;
      fine_x_q <= fine_x_d;
      w_q      <= w_d;
      inc32_q  <= inc32_d;
    end
  end

  assign vramAddr    = v_q;
  assign tempAddr    = t_q;
  assign fineX       = fine_x_q;
  assign writeToggle = w_q;
  assign inc32       = inc32_q;

endmodule

// File: tb/tb_ppu_scroll_registers.sv
// Bench for ppu_scroll_registers: directed vector table, hand sequences for render-glitch and
// protocol corners, then randomized traffic compared against a field-level reference model.
module tb_ppu_scroll_registers;

  logic        clock = 1'b0;
  logic        reset;
  logic        clock_EN, background_EN, sprite_EN;
  logic [8:0]  lineCount;
  logic        incrementX, incrementY, resetX, resetY;
  logic        reg_wr, reg_rd;
  logic [2:0]  reg_addr;
  logic [7:0]  reg_wdata;
  logic [14:0] vramAddr, tempAddr;
  logic [2:0]  fineX;
  logic        writeToggle, inc32;

  always #5 clock = ~clock;

  ppu_scroll_registers dut (
    .clock(clock), .reset(reset), .clock_EN(clock_EN),
    .background_EN(background_EN), .sprite_EN(sprite_EN), .lineCount(lineCount),
    .incrementX(incrementX), .incrementY(incrementY), .resetX(resetX), .resetY(resetY),
    .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .vramAddr(vramAddr), .tempAddr(tempAddr), .fineX(fineX),
    .writeToggle(writeToggle), .inc32(inc32)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic wr, input logic rd, input logic [2:0] a,
                       input logic [7:0] d, input logic ce, input logic bg, input logic sp,
                       input logic [8:0] line, input logic ix, input logic iy,
                       input logic rx, input logic ry);
    reset = rst; reg_wr = wr; reg_rd = rd; reg_addr = a; reg_wdata = d;
    clock_EN = ce; background_EN = bg; sprite_EN = sp; lineCount = line;
    incrementX = ix; incrementY = iy; resetX = rx; resetY = ry;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst, wr, rd;
    logic [2:0]  a;
    logic [7:0]  d;
    logic        ce, ix, iy, rx, ry;
    logic [14:0] ev, et;
    logic [2:0]  efx;
    logic        ew, einc;
    string       name;
  } vec_t;

  vec_t vq[$];

  task automatic vec(input logic rst, input logic wr, input logic rd, input logic [2:0] a,
                     input logic [7:0] d, input logic ce, input logic ix, input logic iy,
                     input logic rx, input logic ry, input logic [14:0] ev,
                     input logic [14:0] et, input logic [2:0] efx, input logic ew,
                     input logic einc, input string name);
    vec_t r;
    r.rst = rst; r.wr = wr; r.rd = rd; r.a = a; r.d = d;
    r.ce = ce; r.ix = ix; r.iy = iy; r.rx = rx; r.ry = ry;
    r.ev = ev; r.et = et; r.efx = efx; r.ew = ew; r.einc = einc; r.name = name;
    vq.push_back(r);
  endtask

  // ---------------- reference model (field level) ----------------
  int m_cx, m_cy, m_ntx, m_nty, m_fy;
  logic [14:0] m_t;
  int m_fx, m_w, m_inc;

  function automatic int m_v();
    return m_fy * 4096 + m_nty * 2048 + m_ntx * 1024 + m_cy * 32 + m_cx;
  endfunction

  task automatic m_set_v(input int val);
    m_cx  = val % 32;
    m_cy  = (val / 32) % 32;
    m_ntx = (val / 1024) % 2;
    m_nty = (val / 2048) % 2;
    m_fy  = (val / 4096) % 8;
  endtask

  task automatic m_inc_x();
    if (m_cx == 31) begin m_cx = 0; m_ntx = 1 - m_ntx; end
    else m_cx = m_cx + 1;
  endtask

  task automatic m_inc_y();
    if (m_fy < 7) m_fy = m_fy + 1;
    else begin
      m_fy = 0;
      if (m_cy == 29) begin m_cy = 0; m_nty = 1 - m_nty; end
      else if (m_cy == 31) m_cy = 0;
      else m_cy = m_cy + 1;
    end
  endtask

  task automatic m_step(input logic rst, input logic wr, input logic rd, input logic [2:0] a,
                        input logic [7:0] d, input logic ce, input logic bg, input logic sp,
                        input int line, input logic ix, input logic iy,
                        input logic rx, input logic ry);
    logic [14:0] nt, old_t;
    int old_w;
    bit v_done, rd_eff;
    if (rst) begin
      m_set_v(0); m_t = '0; m_fx = 0; m_w = 0; m_inc = 0;
      return;
    end
    nt = m_t; old_t = m_t; old_w = m_w; v_done = 0;
    rd_eff = rd && !wr;
    if (wr) begin
      if (a == 0) begin nt[11:10] = d[1:0]; m_inc = int'(d[2]); end
      else if (a == 5) begin
        if (old_w == 0) begin nt[4:0] = d[7:3]; m_fx = int'(d[2:0]); m_w = 1; end
        else begin nt[9:5] = d[7:3]; nt[14:12] = d[2:0]; m_w = 0; end
      end else if (a == 6) begin
        if (old_w == 0) begin nt[13:8] = d[5:0]; nt[14] = 1'b0; m_w = 1; end
        else begin nt[7:0] = d; m_set_v(int'(nt)); v_done = 1; m_w = 0; end
      end
    end else if (rd_eff && a == 2) begin
      m_w = 0;
    end
    if (!v_done && (wr || rd_eff) && a == 7) begin
`ifdef PPUDATA_RENDER_GLITCH_EN
      if ((bg || sp) && (line < 240 || line == 261)) begin m_inc_x(); m_inc_y(); end
      else m_set_v((m_v() + (m_inc != 0 ? 32 : 1)) % 32768);
`else
      m_set_v((m_v() + (m_inc != 0 ? 32 : 1)) % 32768);
`endif
      v_done = 1;
    end
    if (!v_done && ce) begin
      if (ix) m_inc_x();
      if (iy) m_inc_y();
      if (rx) begin m_cx = int'(old_t[4:0]); m_ntx = int'(old_t[10]); end
      if (ry) begin m_fy = int'(old_t[14:12]); m_nty = int'(old_t[11]); m_cy = int'(old_t[9:5]); end
    end
    m_t = nt;
  endtask

  initial begin
    logic        r_rst, r_wr, r_rd, r_ce, r_bg, r_sp, r_ix, r_iy, r_rx, r_ry;
    logic [2:0]  r_a;
    logic [7:0]  r_d;
    int          r_line;
    logic [14:0] exp_v;

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    //   rst wr rd a  d     ce ix iy rx ry  v         t         fx w inc
    vec(1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 15'h0000, 15'h0000, 0, 0, 0, "reset");
    vec(0, 1, 0, 6, 8'h3F, 0, 0, 0, 0, 0, 15'h0000, 15'h3F00, 0, 1, 0, "addr_hi");
    vec(0, 1, 0, 6, 8'h10, 0, 0, 0, 0, 0, 15'h3F10, 15'h3F10, 0, 0, 0, "addr_lo");
    vec(0, 1, 0, 7, 8'h00, 0, 0, 0, 0, 0, 15'h3F11, 15'h3F10, 0, 0, 0, "data_wr_inc1");
    vec(0, 0, 1, 7, 8'h00, 0, 0, 0, 0, 0, 15'h3F12, 15'h3F10, 0, 0, 0, "data_rd_inc1");
    vec(0, 1, 0, 0, 8'h04, 0, 0, 0, 0, 0, 15'h3F12, 15'h3310, 0, 0, 1, "ctrl_inc32");
    vec(0, 1, 0, 7, 8'h00, 0, 0, 0, 0, 0, 15'h3F32, 15'h3310, 0, 0, 1, "data_wr_inc32");
    vec(0, 1, 0, 0, 8'h03, 0, 0, 0, 0, 0, 15'h3F32, 15'h3F10, 0, 0, 0, "ctrl_nt");
    vec(0, 1, 0, 5, 8'h7D, 0, 0, 0, 0, 0, 15'h3F32, 15'h3F0F, 5, 1, 0, "scroll_x");
    vec(0, 1, 0, 5, 8'h5E, 0, 0, 0, 0, 0, 15'h3F32, 15'h6D6F, 5, 0, 0, "scroll_y");
    vec(0, 1, 0, 5, 8'h7D, 0, 0, 0, 0, 0, 15'h3F32, 15'h6D6F, 5, 1, 0, "scroll_x2");
    vec(0, 0, 1, 2, 8'h00, 0, 0, 0, 0, 0, 15'h3F32, 15'h6D6F, 5, 0, 0, "status_clr_w");
    vec(0, 1, 0, 5, 8'h5E, 0, 0, 0, 0, 0, 15'h3F32, 15'h6D6B, 6, 1, 0, "scroll_after_status");
    vec(0, 0, 1, 2, 8'h00, 0, 0, 0, 0, 0, 15'h3F32, 15'h6D6B, 6, 0, 0, "status_clr_w2");
    vec(0, 1, 0, 6, 8'h00, 0, 0, 0, 0, 0, 15'h3F32, 15'h006B, 6, 1, 0, "addr_hi0");
    vec(0, 1, 0, 6, 8'h1F, 0, 0, 0, 0, 0, 15'h001F, 15'h001F, 6, 0, 0, "addr_lo1f");
    vec(0, 0, 0, 0, 8'h00, 1, 1, 0, 0, 0, 15'h0400, 15'h001F, 6, 0, 0, "incx_wrap");
    vec(0, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0, 15'h0400, 15'h001F, 6, 0, 0, "incx_gated");
    vec(0, 1, 0, 5, 8'h18, 0, 0, 0, 0, 0, 15'h0400, 15'h0003, 0, 1, 0, "scroll_cx3");
    vec(0, 1, 0, 5, 8'hEF, 0, 0, 0, 0, 0, 15'h0400, 15'h73A3, 0, 0, 0, "scroll_cy29");
    vec(0, 0, 0, 0, 8'h00, 1, 0, 0, 1, 1, 15'h73A3, 15'h73A3, 0, 0, 0, "copy_xy");
    vec(0, 0, 0, 0, 8'h00, 1, 1, 1, 0, 0, 15'h0804, 15'h73A3, 0, 0, 0, "dot256_cy29");
    vec(0, 1, 0, 5, 8'h18, 0, 0, 0, 0, 0, 15'h0804, 15'h73A3, 0, 1, 0, "scroll_cx3b");
    vec(0, 1, 0, 5, 8'hFF, 0, 0, 0, 0, 0, 15'h0804, 15'h73E3, 0, 0, 0, "scroll_cy31");
    vec(0, 0, 0, 0, 8'h00, 1, 0, 0, 1, 1, 15'h73E3, 15'h73E3, 0, 0, 0, "copy_xy2");
    vec(0, 0, 0, 0, 8'h00, 1, 1, 1, 0, 0, 15'h0004, 15'h73E3, 0, 0, 0, "dot256_cy31");
    vec(0, 0, 0, 0, 8'h00, 1, 0, 1, 0, 0, 15'h1004, 15'h73E3, 0, 0, 0, "incy_fine");
    vec(0, 1, 0, 6, 8'h21, 1, 1, 0, 0, 0, 15'h1005, 15'h21E3, 0, 1, 0, "addr_hi_with_incx");
    vec(0, 1, 0, 6, 8'h40, 1, 1, 0, 0, 0, 15'h2140, 15'h2140, 0, 0, 0, "addr_copy_beats_incx");
    vec(0, 1, 0, 0, 8'h03, 0, 0, 0, 0, 0, 15'h2140, 15'h2D40, 0, 0, 0, "ctrl_nt3");
    vec(0, 1, 0, 5, 8'hFF, 0, 0, 0, 0, 0, 15'h2140, 15'h2D5F, 7, 1, 0, "scroll_x_max");
    vec(0, 1, 0, 5, 8'hFF, 0, 0, 0, 0, 0, 15'h2140, 15'h7FFF, 7, 0, 0, "scroll_y_max");
    vec(0, 0, 0, 0, 8'h00, 1, 0, 0, 1, 1, 15'h7FFF, 15'h7FFF, 7, 0, 0, "copy_all");
    vec(0, 1, 0, 6, 8'h3F, 0, 0, 0, 0, 0, 15'h7FFF, 15'h3FFF, 7, 1, 0, "addr_hi_mid");
    vec(1, 1, 0, 7, 8'h00, 1, 1, 0, 0, 0, 15'h0000, 15'h0000, 0, 0, 0, "reset_mid_frame");

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst, vq[i].wr, vq[i].rd, vq[i].a, vq[i].d, vq[i].ce, 0, 0, 0,
            vq[i].ix, vq[i].iy, vq[i].rx, vq[i].ry);
      tick();
      check({vq[i].name, ".v"},   32'(vramAddr),    32'(vq[i].ev));
      check({vq[i].name, ".t"},   32'(tempAddr),    32'(vq[i].et));
      check({vq[i].name, ".fx"},  32'(fineX),       32'(vq[i].efx));
      check({vq[i].name, ".w"},   32'(writeToggle), 32'(vq[i].ew));
      check({vq[i].name, ".inc"}, 32'(inc32),       32'(vq[i].einc));
    end

    // ---------------- hand sequences ----------------
    // PPUDATA access during a visible line with background on (v=0)
    drive(0, 1, 0, 7, 0, 0, 1, 0, 9'd100, 0, 0, 0, 0);
    tick();
`ifdef PPUDATA_RENDER_GLITCH_EN
    check("glitch_line100", 32'(vramAddr), 32'h1001);
`else
    check("glitch_line100", 32'(vramAddr), 32'h0001);
`endif
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    // Line 240 is post-render: linear step in every build
    drive(0, 1, 0, 7, 0, 0, 1, 0, 9'd240, 0, 0, 0, 0);
    tick();
    check("data_line240", 32'(vramAddr), 32'h0001);
    // Pre-render line with sprites only counts as rendering
    drive(0, 0, 1, 7, 0, 0, 0, 1, 9'd261, 0, 0, 0, 0);
    tick();
`ifdef PPUDATA_RENDER_GLITCH_EN
    exp_v = 15'h1002;
`else
    exp_v = 15'h0002;
`endif
    check("data_prerender", 32'(vramAddr), 32'(exp_v));
    // Simultaneous write+read of PPUDATA advances v only once
    drive(0, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    check("data_wr_rd_once", 32'(vramAddr), 32'(exp_v + 15'd1));
    // Write wins over a concurrent status read: w must stay set
    drive(0, 1, 0, 5, 8'h08, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    check("w_after_scroll", 32'(writeToggle), 32'd1);
    drive(0, 1, 1, 2, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    check("w_wr_rd_conflict", 32'(writeToggle), 32'd1);
    drive(0, 0, 1, 2, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    check("w_status_read", 32'(writeToggle), 32'd0);

    // ---------------- randomized traffic vs model ----------------
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    m_step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    for (int n = 0; n < 3000; n++) begin
      r_rst  = ($urandom_range(0, 199) == 0);
      r_wr   = ($urandom_range(0, 3) == 0);
      r_rd   = ($urandom_range(0, 5) == 0);
      r_a    = 3'($urandom_range(0, 7));
      r_d    = 8'($urandom);
      r_ce   = 1'($urandom_range(0, 1));
      r_bg   = 1'($urandom_range(0, 1));
      r_sp   = ($urandom_range(0, 3) == 0);
      r_line = int'($urandom_range(0, 261));
      r_ix   = ($urandom_range(0, 3) == 0);
      r_iy   = ($urandom_range(0, 3) == 0);
      r_rx   = ($urandom_range(0, 7) == 0);
      r_ry   = ($urandom_range(0, 7) == 0);
      drive(r_rst, r_wr, r_rd, r_a, r_d, r_ce, r_bg, r_sp, 9'(r_line), r_ix, r_iy, r_rx, r_ry);
      m_step(r_rst, r_wr, r_rd, r_a, r_d, r_ce, r_bg, r_sp, r_line, r_ix, r_iy, r_rx, r_ry);
      tick();
      check($sformatf("rand%0d.v", n),   32'(vramAddr),    32'(m_v()));
      check($sformatf("rand%0d.t", n),   32'(tempAddr),    32'(m_t));
      check($sformatf("rand%0d.fx", n),  32'(fineX),       32'(m_fx));
      check($sformatf("rand%0d.w", n),   32'(writeToggle), 32'(m_w));
      check($sformatf("rand%0d.inc", n), 32'(inc32),       32'(m_inc));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
